// File: rtl/regfile_np.sv
// Parametrised register file: one write port, two registered read ports with
// same-cycle write forwarding, a per-register pending scoreboard, sync clear.
module regfile_np #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        writenum,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     ren_a,
  input  logic [ADDR_W-1:0]        readnum_a,
  output logic [DATA_W-1:0]        data_out_a,
  output logic                     valid_a,
  input  logic                     ren_b,
  input  logic [ADDR_W-1:0]        readnum_b,
  output logic [DATA_W-1:0]        data_out_b,
  output logic                     valid_b,
  input  logic                     reserve,
  input  logic [ADDR_W-1:0]        reservenum,
  input  logic                     clr,
  output logic [(2**ADDR_W)-1:0]   pending
);

  localparam int unsigned NREGS = 2**ADDR_W;
  localparam logic        HARD_R0 = (ZERO_R0 != 0);

  logic [DATA_W-1:0]            regs [NREGS];
  logic                         wr_ok;
  logic                         rs_ok;
  logic [NREGS-1:0]             pend_nxt;
  logic [1:0][ADDR_W-1:0]       rnum;
  logic [1:0][DATA_W-1:0]       rd_data;
  logic [1:0]                   rd_valid;

  always_comb begin
    wr_ok = write   && !clr && !(HARD_R0 && (writenum   == '0));
    rs_ok = reserve && !clr && !(HARD_R0 && (reservenum == '0));
  end

  // Reserve is applied after the write clear so a same-cycle reserve wins.
  always_comb begin
    pend_nxt = pending;
    if (clr) begin
      pend_nxt = '0;
    end else begin
      if (wr_ok) pend_nxt[writenum]   = 1'b0;
      if (rs_ok) pend_nxt[reservenum] = 1'b1;
    end
  end

  always_comb begin
    rnum[0] = readnum_a;
    rnum[1] = readnum_b;
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p]  = regs[rnum[p]];
      rd_valid[p] = !pending[rnum[p]];
      if (clr || (HARD_R0 && (rnum[p] == '0))) begin
        rd_data[p]  = '0;
        rd_valid[p] = 1'b1;
      end else if (wr_ok && (writenum == rnum[p])) begin
        rd_data[p]  = data_in;
        rd_valid[p] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[writenum] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= pend_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_a <= '0;
      valid_a    <= 1'b0;
      data_out_b <= '0;
      valid_b    <= 1'b0;
    end else begin
      valid_a <= ren_a && rd_valid[0];
      valid_b <= ren_b && rd_valid[1];
      if (ren_a) data_out_a <= rd_data[0];
      if (ren_b) data_out_b <= rd_data[1];
    end
  end

endmodule

// File: tb/tb_regfile_np.sv
// Bench for regfile_np: two instances (ZERO_R0=0 and 1) share stimulus; a
// reference model pushes expected read results that a negedge monitor pops.
module tb_regfile_np;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        write, ren_a, ren_b, reserve, clr;
  logic [2:0]  writenum, readnum_a, readnum_b, reservenum;
  logic [15:0] data_in;

  logic [15:0] dout_a [2];
  logic [15:0] dout_b [2];
  logic        va [2];
  logic        vb [2];
  logic [7:0]  pend [2];

  always #5 clk = ~clk;

  regfile_np #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
    .ren_a(ren_a), .readnum_a(readnum_a), .data_out_a(dout_a[0]), .valid_a(va[0]),
    .ren_b(ren_b), .readnum_b(readnum_b), .data_out_b(dout_b[0]), .valid_b(vb[0]),
    .reserve(reserve), .reservenum(reservenum), .clr(clr), .pending(pend[0])
  );

  regfile_np #(.DATA_W(16), .ADDR_W(3), .ZERO_R0(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .data_in(data_in),
    .ren_a(ren_a), .readnum_a(readnum_a), .data_out_a(dout_a[1]), .valid_a(va[1]),
    .ren_b(ren_b), .readnum_b(readnum_b), .data_out_b(dout_b[1]), .valid_b(vb[1]),
    .reserve(reserve), .reservenum(reservenum), .clr(clr), .pending(pend[1])
  );

  typedef struct {
    int unsigned due;
    logic [15:0] da;
    logic        va;
    logic [15:0] db;
    logic        vb;
    logic [7:0]  pd;
  } exp_t;

  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [15:0] mreg [2][8];
  logic [7:0]  mpend [2];
  logic [15:0] mlast_a [2];
  logic [15:0] mlast_b [2];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: compares every entry whose edge has already occurred.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int z = 0; z < 2; z++) begin
      have = 1'b1;
      while (have) begin
        have = 1'b0;
        if (z == 0 && sb0.size() > 0 && sb0[0].due <= cyc) begin e = sb0.pop_front(); have = 1'b1; end
        if (z == 1 && sb1.size() > 0 && sb1[0].due <= cyc) begin e = sb1.pop_front(); have = 1'b1; end
        if (have) begin
          n_checks += 5;
          if (dout_a[z] !== e.da) $display("FAIL sb_data_a[%0d] cyc %0d: got %h expected %h", z, cyc, dout_a[z], e.da);
          else n_pass++;
          if (va[z] !== e.va) $display("FAIL sb_valid_a[%0d] cyc %0d: got %b expected %b", z, cyc, va[z], e.va);
          else n_pass++;
          if (dout_b[z] !== e.db) $display("FAIL sb_data_b[%0d] cyc %0d: got %h expected %h", z, cyc, dout_b[z], e.db);
          else n_pass++;
          if (vb[z] !== e.vb) $display("FAIL sb_valid_b[%0d] cyc %0d: got %b expected %b", z, cyc, vb[z], e.vb);
          else n_pass++;
          if (pend[z] !== e.pd) $display("FAIL sb_pending[%0d] cyc %0d: got %b expected %b", z, cyc, pend[z], e.pd);
          else n_pass++;
        end
      end
    end
  end

  task automatic idle();
    write = 0; ren_a = 0; ren_b = 0; reserve = 0; clr = 0;
    writenum = 0; readnum_a = 0; readnum_b = 0; reservenum = 0; data_in = 0;
  endtask

  task automatic model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < 8; i++) mreg[z][i] = 16'h0;
      mpend[z] = 8'h0;
      mlast_a[z] = 16'h0;
      mlast_b[z] = 16'h0;
    end
  endtask

  task automatic model_read(input int z, input logic [2:0] a, output logic [15:0] d, output logic v);
    logic wacc;
    wacc = write && !clr && !(z == 1 && writenum == 3'd0);
    if (clr || (z == 1 && a == 3'd0)) begin d = 16'h0; v = 1'b1; end
    else if (wacc && writenum == a) begin d = data_in; v = 1'b1; end
    else begin d = mreg[z][a]; v = !mpend[z][a]; end
  endtask

  // Record expectations for the current inputs, advance the model, then clock.
  task automatic tick();
    exp_t        e;
    logic [15:0] d;
    logic        v;
    for (int z = 0; z < 2; z++) begin
      e.due = cyc + 1;
      model_read(z, readnum_a, d, v);
      if (ren_a) begin e.da = d; e.va = v; mlast_a[z] = d; end
      else begin e.da = mlast_a[z]; e.va = 1'b0; end
      model_read(z, readnum_b, d, v);
      if (ren_b) begin e.db = d; e.vb = v; mlast_b[z] = d; end
      else begin e.db = mlast_b[z]; e.vb = 1'b0; end
      if (clr) begin
        for (int i = 0; i < 8; i++) mreg[z][i] = 16'h0;
        mpend[z] = 8'h0;
      end else begin
        if (write && !(z == 1 && writenum == 3'd0)) begin
          mreg[z][writenum] = data_in;
          mpend[z][writenum] = 1'b0;
        end
        if (reserve && !(z == 1 && reservenum == 3'd0)) mpend[z][reservenum] = 1'b1;
      end
      e.pd = mpend[z];
      if (z == 0) sb0.push_back(e); else sb1.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    model_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if (dout_a[0] !== 16'h0 || dout_b[0] !== 16'h0 || va[0] !== 1'b0 || vb[0] !== 1'b0 || pend[0] !== 8'h0)
      $display("FAIL reset_state: got a=%h b=%h va=%b vb=%b pend=%b required all zero", dout_a[0], dout_b[0], va[0], vb[0], pend[0]);
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    idle(); write = 1; writenum = 3; data_in = 16'h1234; tick();
    idle(); write = 1; writenum = 5; data_in = 16'hBEEF; tick();
    idle(); ren_a = 1; readnum_a = 3; ren_b = 1; readnum_b = 5; tick();
    n_checks++;
    if (dout_a[0] !== 16'h1234 || va[0] !== 1'b1)
      $display("FAIL read_r3: got %h/%b required 1234/1", dout_a[0], va[0]);
    else n_pass++;
    n_checks++;
    if (dout_b[0] !== 16'hBEEF || vb[0] !== 1'b1)
      $display("FAIL read_r5: got %h/%b required beef/1", dout_b[0], vb[0]);
    else n_pass++;
  endtask

  task automatic test_bypass();
    idle(); write = 1; writenum = 2; data_in = 16'h00A5; ren_a = 1; readnum_a = 2; tick();
    n_checks++;
    if (dout_a[0] !== 16'h00A5 || va[0] !== 1'b1)
      $display("FAIL bypass_r2: got %h/%b required 00a5/1", dout_a[0], va[0]);
    else n_pass++;
  endtask

  task automatic test_reserve();
    idle(); reserve = 1; reservenum = 4; tick();
    n_checks++;
    if (pend[0] !== 8'b0001_0000) $display("FAIL reserve_r4: got pending %b required 00010000", pend[0]);
    else n_pass++;
    idle(); ren_a = 1; readnum_a = 4; tick();
    n_checks++;
    if (va[0] !== 1'b0) $display("FAIL stale_r4: got valid_a %b required 0", va[0]);
    else n_pass++;
    idle(); write = 1; writenum = 4; data_in = 16'h7777; ren_b = 1; readnum_b = 4; tick();
    n_checks++;
    if (dout_b[0] !== 16'h7777 || vb[0] !== 1'b1 || pend[0] !== 8'h0)
      $display("FAIL fill_r4: got %h/%b pend %b required 7777/1 pend 0", dout_b[0], vb[0], pend[0]);
    else n_pass++;
    // A reserve does not invalidate a read issued in the same cycle.
    idle(); reserve = 1; reservenum = 3; ren_a = 1; readnum_a = 3; tick();
    n_checks++;
    if (va[0] !== 1'b1 || dout_a[0] !== 16'h1234 || pend[0][3] !== 1'b1)
      $display("FAIL reserve_read_same: got %h/%b pend %b required 1234/1 pend[3]=1", dout_a[0], va[0], pend[0]);
    else n_pass++;
  endtask

  task automatic test_write_reserve_clr();
    idle(); write = 1; writenum = 6; data_in = 16'h6666; reserve = 1; reservenum = 6; tick();
    n_checks++;
    if (pend[0][6] !== 1'b1) $display("FAIL wr_rsv_r6: got pending %b required bit6=1", pend[0]);
    else n_pass++;
    idle(); ren_a = 1; readnum_a = 6; tick();
    n_checks++;
    if (dout_a[0] !== 16'h6666 || va[0] !== 1'b0)
      $display("FAIL read_r6: got %h/%b required 6666/0", dout_a[0], va[0]);
    else n_pass++;
    idle(); clr = 1; write = 1; writenum = 1; data_in = 16'hFFFF; reserve = 1; reservenum = 2;
    ren_a = 1; readnum_a = 1; tick();
    n_checks++;
    if (dout_a[0] !== 16'h0 || va[0] !== 1'b1 || pend[0] !== 8'h0)
      $display("FAIL clr_cycle: got %h/%b pend %b required 0000/1 pend 0", dout_a[0], va[0], pend[0]);
    else n_pass++;
    idle(); ren_a = 1; readnum_a = 1; ren_b = 1; readnum_b = 5; tick();
    n_checks++;
    if (dout_a[0] !== 16'h0 || dout_b[0] !== 16'h0 || va[0] !== 1'b1 || vb[0] !== 1'b1)
      $display("FAIL after_clr: got a=%h b=%h va=%b vb=%b required 0/0/1/1", dout_a[0], dout_b[0], va[0], vb[0]);
    else n_pass++;
  endtask

  task automatic test_zero_r0();
    idle(); write = 1; writenum = 0; data_in = 16'hABCD; reserve = 1; reservenum = 0; tick();
    idle(); ren_a = 1; readnum_a = 0; tick();
    n_checks++;
    if (dout_a[1] !== 16'h0 || va[1] !== 1'b1 || pend[1][0] !== 1'b0)
      $display("FAIL zero_r0_on: got %h/%b pend %b required 0000/1 pend[0]=0", dout_a[1], va[1], pend[1]);
    else n_pass++;
    n_checks++;
    if (dout_a[0] !== 16'hABCD) $display("FAIL zero_r0_off: got %h required abcd", dout_a[0]);
    else n_pass++;
    idle(); write = 1; writenum = 0; data_in = 16'h1111; ren_b = 1; readnum_b = 0; tick();
    n_checks++;
    if (dout_b[1] !== 16'h0 || dout_b[0] !== 16'h1111)
      $display("FAIL r0_bypass: got z1=%h z0=%h required 0000/1111", dout_b[1], dout_b[0]);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    idle(); write = 1; writenum = 7; data_in = 16'h5555; reserve = 1; reservenum = 7; tick();
    idle(); ren_a = 1; readnum_a = 7; tick();
    idle();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dout_a[0] !== 16'h0 || va[0] !== 1'b0 || pend[0] !== 8'h0 || pend[1] !== 8'h0)
      $display("FAIL async_reset: got %h/%b pend %b/%b required all zero", dout_a[0], va[0], pend[0], pend[1]);
    else n_pass++;
    #1 rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    idle(); ren_a = 1; readnum_a = 7; tick();
    n_checks++;
    if (dout_a[0] !== 16'h0 || va[0] !== 1'b1)
      $display("FAIL read_r7_after_reset: got %h/%b required 0000/1", dout_a[0], va[0]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      write      = 1'($urandom_range(0, 1));
      writenum   = 3'($urandom_range(0, 7));
      data_in    = 16'($urandom);
      ren_a      = 1'($urandom_range(0, 3) != 0);
      readnum_a  = 3'($urandom_range(0, 7));
      ren_b      = 1'($urandom_range(0, 3) != 0);
      readnum_b  = (i % 4 == 0) ? readnum_a : 3'($urandom_range(0, 7));
      reserve    = 1'($urandom_range(0, 2) == 0);
      reservenum = (i % 5 == 0) ? writenum : 3'($urandom_range(0, 7));
      clr        = 1'($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_reserve();
    test_write_reserve_clr();
    test_zero_r0();
    test_async_reset();
    test_back_to_back();
    @(negedge clk);
    #1;
    n_checks++;
    if (sb0.size() != 0 || sb1.size() != 0)
      $display("FAIL scoreboard_drain: got %0d/%0d entries left required 0", sb0.size(), sb1.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
